// File: rtl/instruction_queue.sv
// Circular instruction queue: accepts packed bundles of up to four ops per cycle and presents the
// four oldest entries to the issue stage, which retires up to four per cycle in program order.
module instruction_queue #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 16,
    parameter int PTRW  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_op_a,
    input  logic [WIDTH-1:0] in_op_b,
    input  logic [WIDTH-1:0] in_op_c,
    input  logic [WIDTH-1:0] in_op_d,
    input  logic             in_valid_a,
    input  logic             in_valid_b,
    input  logic             in_valid_c,
    input  logic             in_valid_d,
    output logic             enq_accept,
    output logic [PTRW:0]    free_count,
    output logic [PTRW:0]    count,
    output logic [WIDTH-1:0] out_op_a,
    output logic [WIDTH-1:0] out_op_b,
    output logic [WIDTH-1:0] out_op_c,
    output logic [WIDTH-1:0] out_op_d,
    output logic             out_valid_a,
    output logic             out_valid_b,
    output logic             out_valid_c,
    output logic             out_valid_d,
    input  logic [2:0]       deq_req
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] inOps [4];
    logic [PTRW-1:0]  headQ, tailQ;
    logic [PTRW:0]    countQ, freeQ;
    logic [PTRW:0]    enqAdd, deqAdd;
    logic [2:0]       enqN, deqReqSat, deqN;

    assign inOps[0] = in_op_a;
    assign inOps[1] = in_op_b;
    assign inOps[2] = in_op_c;
    assign inOps[3] = in_op_d;

    // Only the leading run of set valids counts; anything after the first gap is dropped.
    always_comb begin
        enqN = 3'd0;
        if (in_valid_a) begin
            enqN = 3'd1;
            if (in_valid_b) begin
                enqN = 3'd2;
                if (in_valid_c) begin
                    enqN = 3'd3;
                    if (in_valid_d) enqN = 3'd4;
                end
            end
        end
    end

    always_comb begin
        deqReqSat = (deq_req > 3'd4) ? 3'd4 : deq_req;
        deqN      = ((PTRW+1)'(deqReqSat) > countQ) ? countQ[2:0] : deqReqSat;
    end

    assign enq_accept = !reset && !flush && (enqN != 3'd0) && ((PTRW+1)'(enqN) <= freeQ);
    assign enqAdd     = enq_accept ? (PTRW+1)'(enqN) : '0;
    assign deqAdd     = (PTRW+1)'(deqN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
            freeQ  <= (PTRW+1)'(DEPTH);
        end else if (flush) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
            freeQ  <= (PTRW+1)'(DEPTH);
        end else begin
            headQ  <= headQ + PTRW'(deqN);
            tailQ  <= tailQ + enqAdd[PTRW-1:0];
            countQ <= countQ + enqAdd - deqAdd;
            freeQ  <= freeQ - enqAdd + deqAdd;
        end
    end

    // Storage is intentionally unreset; validity is tracked solely by countQ.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (enq_accept && (3'(k) < enqN)) mem[tailQ + PTRW'(k)] <= inOps[k];
        end
    end

    assign out_op_a = mem[headQ];
    assign out_op_b = mem[headQ + PTRW'(1)];
    assign out_op_c = mem[headQ + PTRW'(2)];
    assign out_op_d = mem[headQ + PTRW'(3)];

    assign out_valid_a = countQ > (PTRW+1)'(0);
    assign out_valid_b = countQ > (PTRW+1)'(1);
    assign out_valid_c = countQ > (PTRW+1)'(2);
    assign out_valid_d = countQ > (PTRW+1)'(3);

    assign count      = countQ;
    assign free_count = freeQ;

endmodule
